// File: rtl/dcache_wb_pkg.sv
// Shared definitions for the write-back data cache: FSM states, access-size codes,
// address-split width helpers and byte-lane helpers.
package dcache_wb_pkg;

  typedef enum logic [2:0] {StIdle, StWb, StFill, StDone, StFlush} state_e;

  localparam logic [1:0] WlByte = 2'd0;
  localparam logic [1:0] WlHalf = 2'd1;
  localparam logic [1:0] WlWord = 2'd2;

  function automatic int unsigned off_w(input int unsigned linewords);
    return $clog2(linewords);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addrbits, input int unsigned linewords,
                                        input int unsigned lines);
    return addrbits - off_w(linewords) - idx_w(lines) - 2;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] len, input logic [1:0] off);
    case (len)
      WlByte:  lane_be = 4'b0001 << off;
      WlHalf:  lane_be = off[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] len);
    case (len)
      WlByte:  lane_wdata = {4{d[7:0]}};
      WlHalf:  lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Low address bits below the access size are ignored (misaligned accesses round down).
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] len,
                                               input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (len)
      WlByte:  lane_extract = {24'd0, sh[7:0]};
      WlHalf:  lane_extract = {16'd0, off[1] ? w[31:16] : w[15:0]};
      default: lane_extract = w;
    endcase
  endfunction

endpackage

// File: rtl/dcache_wb_dataram.sv
// Line data storage: single port, per-byte write enables, combinational read.
module dcache_wb_dataram #(
  parameter int unsigned WORDS    = 128,
  parameter int unsigned DATABITS = 32
) (
  input  logic                       clk,
  input  logic [$clog2(WORDS)-1:0]   addr,
  input  logic                       we,
  input  logic [DATABITS/8-1:0]      be,
  input  logic [DATABITS-1:0]        wdata,
  output logic [DATABITS-1:0]        rdata
);

  logic [DATABITS-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATABITS / 8; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with burst fill/evict and full flush.
// Optional hit/miss counters are built when DCACHE_WB_STATS_EN is defined.
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int unsigned DATABITS  = 32,
  parameter int unsigned ADDRBITS  = 32,
  parameter int unsigned LINEWORDS = 8,
  parameter int unsigned LINES     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] dcache_addr,
  input  logic [DATABITS-1:0] dcache_in,
  input  logic                dcache_rdreq,
  input  logic                dcache_wrreq,
  input  logic [1:0]          dcache_wordlen,
  output logic [DATABITS-1:0] dcache_out,
  output logic                dcache_out_valid,
  output logic                dcache_ready,
  input  logic                dcache_flush,
`ifdef DCACHE_WB_STATS_EN
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
`endif
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_in,
  input  logic [DATABITS-1:0] mem_out,
  input  logic                mem_out_valid,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  output logic [15:0]         mem_burstlen
);

  localparam int unsigned OffW = off_w(LINEWORDS);
  localparam int unsigned IdxW = idx_w(LINES);
  localparam int unsigned TagW = tag_w(ADDRBITS, LINEWORDS, LINES);

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TagW-1:0]     tag_q [LINES];
  logic [IdxW-1:0]     idx_q;
  logic [OffW:0]       beat_q;  // MSB set once every fill request has been issued
  logic [OffW-1:0]     fill_q;
  logic                flushing_q, hit_vld_q, req_wr_q;
  logic [TagW-1:0]     req_tag_q;
  logic [OffW-1:0]     req_word_q;
  logic [1:0]          req_off_q, req_len_q;
  logic [31:0]         req_data_q, out_q;

  logic [IdxW+OffW-1:0] ram_addr;
  logic                 ram_we;
  logic [3:0]           ram_be;
  logic [31:0]          ram_wdata, ram_rdata;

  logic [TagW-1:0] in_tag;
  logic [IdxW-1:0] in_idx;
  logic [OffW-1:0] in_word;
  logic            accept, in_hit, wb_last, idx_last, done_rd;

  assign in_tag   = dcache_addr[ADDRBITS-1 -: TagW];
  assign in_idx   = dcache_addr[OffW+2 +: IdxW];
  assign in_word  = dcache_addr[2 +: OffW];
  assign accept   = (state_q == StIdle) && !dcache_flush && (dcache_rdreq || dcache_wrreq);
  assign in_hit   = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign wb_last  = beat_q[OffW-1:0] == OffW'(LINEWORDS - 1);
  assign idx_last = idx_q == IdxW'(LINES - 1);
  assign done_rd  = (state_q == StDone) && !req_wr_q;

  dcache_wb_dataram #(
    .WORDS   (LINES * LINEWORDS),
    .DATABITS(DATABITS)
  ) u_dataram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ram_addr  = {in_idx, in_word};
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_wdata = '0;
    mem_addr  = '0;
    mem_in    = '0;
    mem_rdreq = 1'b0;
    mem_wrreq = 1'b0;
    case (state_q)
      StIdle: begin
        if (dcache_flush) begin
          state_d = StFlush;
        end else if (accept) begin
          if (!in_hit) begin
            state_d = (valid_q[in_idx] && dirty_q[in_idx]) ? StWb : StFill;
          end else if (dcache_wrreq) begin
            ram_we    = 1'b1;
            ram_be    = lane_be(dcache_wordlen, dcache_addr[1:0]);
            ram_wdata = lane_wdata(dcache_in, dcache_wordlen);
          end
        end
      end
      StWb: begin
        ram_addr  = {idx_q, beat_q[OffW-1:0]};
        mem_wrreq = 1'b1;
        mem_addr  = {tag_q[idx_q], idx_q, beat_q[OffW-1:0], 2'b00};
        mem_in    = ram_rdata;
        if (wb_last) state_d = !flushing_q ? StFill : (idx_last ? StIdle : StFlush);
      end
      StFill: begin
        ram_addr  = {idx_q, fill_q};
        mem_rdreq = !beat_q[OffW];
        mem_addr  = {req_tag_q, idx_q, beat_q[OffW-1:0], 2'b00};
        if (mem_out_valid) begin
          ram_we    = 1'b1;
          ram_be    = 4'b1111;
          ram_wdata = mem_out;
          if (fill_q == OffW'(LINEWORDS - 1)) state_d = StDone;
        end
      end
      StDone: begin
        ram_addr = {idx_q, req_word_q};
        if (req_wr_q) begin
          ram_we    = 1'b1;
          ram_be    = lane_be(req_len_q, req_off_q);
          ram_wdata = lane_wdata(req_data_q, req_len_q);
        end
        state_d = StIdle;
      end
      StFlush: begin
        if (valid_q[idx_q] && dirty_q[idx_q]) state_d = StWb;
        else if (idx_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      dirty_q    <= '0;
      idx_q      <= '0;
      beat_q     <= '0;
      fill_q     <= '0;
      flushing_q <= 1'b0;
      hit_vld_q  <= 1'b0;
      out_q      <= '0;
      req_wr_q   <= 1'b0;
      req_tag_q  <= '0;
      req_word_q <= '0;
      req_off_q  <= '0;
      req_len_q  <= '0;
      req_data_q <= '0;
    end else begin
      state_q   <= state_d;
      hit_vld_q <= 1'b0;
      case (state_q)
        StIdle: begin
          beat_q <= '0;
          fill_q <= '0;
          if (dcache_flush) begin
            flushing_q <= 1'b1;
            idx_q      <= '0;
          end else if (accept) begin
            if (in_hit) begin
              if (dcache_wrreq) begin
                dirty_q[in_idx] <= 1'b1;
              end else begin
                out_q     <= lane_extract(ram_rdata, dcache_wordlen, dcache_addr[1:0]);
                hit_vld_q <= 1'b1;
              end
            end else begin
              flushing_q <= 1'b0;
              idx_q      <= in_idx;
              req_wr_q   <= dcache_wrreq;
              req_tag_q  <= in_tag;
              req_word_q <= in_word;
              req_off_q  <= dcache_addr[1:0];
              req_len_q  <= dcache_wordlen;
              req_data_q <= dcache_in;
            end
          end
        end
        StWb: begin
          beat_q <= beat_q + 1'b1;
          if (wb_last) begin
            beat_q         <= '0;
            dirty_q[idx_q] <= 1'b0;
            if (flushing_q) idx_q <= idx_q + 1'b1;
          end
        end
        StFill: begin
          if (!beat_q[OffW]) beat_q <= beat_q + 1'b1;
          if (mem_out_valid) fill_q <= fill_q + 1'b1;
        end
        StDone: begin
          valid_q[idx_q] <= 1'b1;
          dirty_q[idx_q] <= req_wr_q;
        end
        StFlush: begin
          beat_q <= '0;
          if (!(valid_q[idx_q] && dirty_q[idx_q])) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StDone) tag_q[idx_q] <= req_tag_q;
  end

  assign dcache_ready     = state_q == StIdle;
  assign dcache_out_valid = hit_vld_q || done_rd;
  assign dcache_out       = done_rd ? lane_extract(ram_rdata, req_len_q, req_off_q) : out_q;
  assign mem_burstlen     = 16'(LINEWORDS);

`ifdef DCACHE_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (accept) begin
      if (in_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      end else if (stat_misses != '1) begin
        stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: vector table, directed burst/flush/reset sequences,
// and randomized traffic checked against a flat byte-memory model.
module tb_dcache_wb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dcache_addr = '0, dcache_in = '0;
  logic        dcache_rdreq = 1'b0, dcache_wrreq = 1'b0, dcache_flush = 1'b0;
  logic [1:0]  dcache_wordlen = '0;
  logic [31:0] dcache_out;
  logic        dcache_out_valid, dcache_ready;
  logic [31:0] mem_addr, mem_in, mem_out;
  logic        mem_out_valid, mem_rdreq, mem_wrreq;
  logic [15:0] mem_burstlen;
`ifdef DCACHE_WB_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  dcache_wb dut (
    .clk             (clk),
    .reset           (reset),
    .dcache_addr     (dcache_addr),
    .dcache_in       (dcache_in),
    .dcache_rdreq    (dcache_rdreq),
    .dcache_wrreq    (dcache_wrreq),
    .dcache_wordlen  (dcache_wordlen),
    .dcache_out      (dcache_out),
    .dcache_out_valid(dcache_out_valid),
    .dcache_ready    (dcache_ready),
    .dcache_flush    (dcache_flush),
`ifdef DCACHE_WB_STATS_EN
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
`endif
    .mem_addr        (mem_addr),
    .mem_in          (mem_in),
    .mem_out         (mem_out),
    .mem_out_valid   (mem_out_valid),
    .mem_rdreq       (mem_rdreq),
    .mem_wrreq       (mem_wrreq),
    .mem_burstlen    (mem_burstlen)
  );

  // Backing memory (4 KiB) with two-cycle read latency; logs every strobed beat.
  logic [31:0] mem_arr [1024];
  logic        mem_clr = 1'b0;
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [31:0] p1_a = '0, p2_a = '0;
  logic [32:0] tr_log [$];
  bit          both_seen = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= '0;
    end else if (mem_wrreq) begin
      mem_arr[mem_addr[11:2]] <= mem_in;
    end
    if (mem_wrreq) tr_log.push_back({1'b0, mem_addr});
    if (mem_rdreq) tr_log.push_back({1'b1, mem_addr});
    if (mem_wrreq && mem_rdreq) both_seen <= 1'b1;
    p1_v <= mem_rdreq && !reset;
    p1_a <= mem_addr;
    p2_v <= p1_v && !reset;
    p2_a <= p1_a;
  end

  assign mem_out_valid = p2_v;
  assign mem_out       = mem_arr[p2_a[11:2]];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_clr = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!dcache_ready && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!dcache_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic do_acc(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] len, output bit vld, output logic [31:0] q,
                        output int lat);
    wait_ready(500);
    dcache_addr    = a;
    dcache_in      = d;
    dcache_wordlen = len;
    dcache_wrreq   = wr;
    dcache_rdreq   = rd;
    @(posedge clk);
    #1;
    dcache_wrreq = 1'b0;
    dcache_rdreq = 1'b0;
    vld = 1'b0;
    q   = '0;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      if (dcache_out_valid) begin
        vld = 1'b1;
        q   = dcache_out;
        lat = i;
        break;
      end
      if (dcache_ready) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_flush();
    wait_ready(500);
    dcache_flush = 1'b1;
    @(posedge clk);
    #1;
    dcache_flush = 1'b0;
    wait_ready(400);
  endtask

  // Reference: the CPU-visible memory is just a flat byte array.
  logic [7:0] ref_mem [1024];

  function automatic int acc_size(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] len);
    int n = acc_size(len);
    int base = int'(a[9:0]) & ~(n - 1);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    int n = acc_size(len);
    int base = int'(a[9:0]) & ~(n - 1);
    for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(d >> (8 * i));
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  len;
    bit          exp_vld;
    logic [31:0] exp_q;
  } vec_t;

  vec_t        vecs [16];
  bit          r_vld;
  logic [31:0] r_q;
  int          r_lat;
  int          mark;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h101, 32'h000000aa, 2'd0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h103, 32'h000000bb, 2'd0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h100, 32'h0,        2'd2, 1'b1, 32'hbb00aa00};
    vecs[3]  = '{1'b0, 1'b1, 32'h103, 32'h0,        2'd0, 1'b1, 32'h000000bb};
    vecs[4]  = '{1'b0, 1'b1, 32'h102, 32'h0,        2'd1, 1'b1, 32'h0000bb00};
    vecs[5]  = '{1'b0, 1'b1, 32'h103, 32'h0,        2'd1, 1'b1, 32'h0000bb00};
    vecs[6]  = '{1'b0, 1'b1, 32'h100, 32'h0,        2'd1, 1'b1, 32'h0000aa00};
    vecs[7]  = '{1'b0, 1'b1, 32'h101, 32'h0,        2'd0, 1'b1, 32'h000000aa};
    vecs[8]  = '{1'b1, 1'b1, 32'h080, 32'h0000aa55, 2'd2, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h080, 32'h0,        2'd2, 1'b1, 32'h0000aa55};
    vecs[10] = '{1'b1, 1'b0, 32'h106, 32'h1234beef, 2'd1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h104, 32'h0,        2'd3, 1'b1, 32'hbeef0000};
    vecs[12] = '{1'b1, 1'b0, 32'h08b, 32'hcafef00d, 2'd2, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'h088, 32'h0,        2'd2, 1'b1, 32'hcafef00d};
    vecs[14] = '{1'b0, 1'b1, 32'h08a, 32'h0,        2'd0, 1'b1, 32'h000000fe};
    vecs[15] = '{1'b0, 1'b1, 32'h180, 32'h0,        2'd2, 1'b1, 32'h0};

    // Reset state
    do_reset();
    chk("rst_ready", 32'(dcache_ready), 32'd1);
    chk("rst_out_valid", 32'(dcache_out_valid), 32'd0);
    chk("rst_mem_rdreq", 32'(mem_rdreq), 32'd0);
    chk("rst_mem_wrreq", 32'(mem_wrreq), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_out", dcache_out, 32'd0);
    chk("burstlen", 32'(mem_burstlen), 32'd8);

    // Write-allocate fill, then a hit with no memory traffic
    mark = tr_log.size();
    do_acc(1'b1, 1'b0, 32'h80, 32'h0fff0001, 2'd2, r_vld, r_q, r_lat);
    wait_ready(100);
    chk("fill_beats", 32'(tr_log.size() - mark), 32'd8);
    chk("fill_first_rd", 32'(tr_log[mark][32]), 32'd1);
    chk("fill_first_addr", tr_log[mark][31:0], 32'h80);
    chk("fill_last_addr", tr_log[mark+7][31:0], 32'h9c);
    do_acc(1'b0, 1'b1, 32'h80, 32'h0, 2'd2, r_vld, r_q, r_lat);
    chk("hit_valid", 32'(r_vld), 32'd1);
    chk("hit_latency", 32'(r_lat), 32'd0);
    chk("hit_data", r_q, 32'h0fff0001);
    chk("hit_no_traffic", 32'(tr_log.size() - mark), 32'd8);

    foreach (vecs[i]) begin
      do_acc(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].len, r_vld, r_q, r_lat);
      chk($sformatf("vec%0d_valid", i), 32'(r_vld), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) chk($sformatf("vec%0d_data", i), r_q, vecs[i].exp_q);
    end

    // Dirty victim is written back before the new line is filled
    do_reset();
    do_acc(1'b1, 1'b0, 32'h0, 32'h11111111, 2'd2, r_vld, r_q, r_lat);
    wait_ready(100);
    mark = tr_log.size();
    do_acc(1'b0, 1'b1, 32'h200, 32'h0, 2'd2, r_vld, r_q, r_lat);
    chk("evict_rd_data", r_q, 32'h0);
    chk("evict_beats", 32'(tr_log.size() - mark), 32'd16);
    for (int i = 0; i < 16 && mark + i < tr_log.size(); i++) begin
      chk($sformatf("evict_kind%0d", i), 32'(tr_log[mark+i][32]), (i < 8) ? 32'd0 : 32'd1);
      chk($sformatf("evict_addr%0d", i), tr_log[mark+i][31:0],
          (i < 8) ? 32'(4 * i) : 32'(32'h200 + 4 * (i - 8)));
    end
    chk("evict_mem_word", mem_arr[0], 32'h11111111);
    do_acc(1'b0, 1'b1, 32'h0, 32'h0, 2'd2, r_vld, r_q, r_lat);
    chk("evict_refill_data", r_q, 32'h11111111);

    // Flush writes back dirty lines at index 0 then index 4
    do_reset();
    do_acc(1'b1, 1'b0, 32'h0, 32'ha0a0a0a0, 2'd2, r_vld, r_q, r_lat);
    do_acc(1'b1, 1'b0, 32'h84, 32'hb4b4b4b4, 2'd2, r_vld, r_q, r_lat);
    wait_ready(100);
    mark = tr_log.size();
    dcache_flush = 1'b1;
    @(posedge clk);
    #1;
    dcache_flush = 1'b0;
    chk("flush_ready_low", 32'(dcache_ready), 32'd0);
    wait_ready(400);
    chk("flush_beats", 32'(tr_log.size() - mark), 32'd16);
    if (tr_log.size() - mark >= 16) begin
      chk("flush_first_addr", tr_log[mark][31:0], 32'h0);
      chk("flush_second_addr", tr_log[mark+8][31:0], 32'h80);
      chk("flush_all_writes", 32'(tr_log[mark][32] | tr_log[mark+15][32]), 32'd0);
    end
    chk("flush_mem0", mem_arr[0], 32'ha0a0a0a0);
    chk("flush_mem84", mem_arr[32'h84 >> 2], 32'hb4b4b4b4);
    mark = tr_log.size();
    do_acc(1'b0, 1'b1, 32'h0, 32'h0, 2'd2, r_vld, r_q, r_lat);
    chk("flush_hit0_lat", 32'(r_lat), 32'd0);
    chk("flush_hit0_data", r_q, 32'ha0a0a0a0);
    do_acc(1'b0, 1'b1, 32'h84, 32'h0, 2'd2, r_vld, r_q, r_lat);
    chk("flush_hit4_data", r_q, 32'hb4b4b4b4);
    chk("flush_hits_no_traffic", 32'(tr_log.size() - mark), 32'd0);

    // Reset during the third fill beat aborts the burst
    do_reset();
    wait_ready(10);
    dcache_addr    = 32'h300;
    dcache_wordlen = 2'd2;
    dcache_rdreq   = 1'b1;
    @(posedge clk);
    #1;
    dcache_rdreq = 1'b0;
    begin
      int beats = 0;
      for (int i = 0; i < 40 && beats < 3; i++) begin
        if (mem_rdreq) beats++;
        if (beats < 3) begin
          @(posedge clk);
          #1;
        end
      end
      chk("abort_reached_beat3", 32'(beats), 32'd3);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rdreq_low", 32'(mem_rdreq), 32'd0);
    chk("abort_wrreq_low", 32'(mem_wrreq), 32'd0);
    chk("abort_ready", 32'(dcache_ready), 32'd1);
    reset = 1'b0;
    mark = tr_log.size();
    do_acc(1'b0, 1'b1, 32'h300, 32'h0, 2'd2, r_vld, r_q, r_lat);
    chk("abort_reread_miss", 32'(tr_log.size() - mark), 32'd8);
    chk("abort_reread_data", r_q, 32'h0);

    // Randomized traffic against the flat-memory model
    do_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    for (int n = 0; n < 400; n++) begin
      int unsigned r = $urandom_range(0, 99);
      logic [31:0] a = 32'($urandom_range(0, 32'h3ff));
      logic [31:0] d = $urandom;
      logic [1:0]  len = 2'($urandom_range(0, 3));
      bit wr = r < 50;
      bit rd = (r >= 50) || (r >= 42);
      if (r < 3) begin
        do_flush();
      end else begin
        do_acc(wr, rd, a, d, len, r_vld, r_q, r_lat);
        chk($sformatf("rnd%0d_valid", n), 32'(r_vld), wr ? 32'd0 : 32'd1);
        if (wr) ref_write(a, len, d);
        else chk($sformatf("rnd%0d_data@%h", n, a), r_q, ref_read(a, len));
      end
    end
    do_flush();
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("image_word%0d", i), mem_arr[i],
          {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    end
    chk("never_rd_and_wr", 32'(both_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 SHALL have parameter DATABITS, default 32, meaning CPU/memory word width (fixed 32; byte lanes = 4).
REQ-002 SHALL have parameter ADDRBITS, default 32, meaning byte-address width.
REQ-003 SHALL have parameter LINEWORDS, default 8, meaning words per line (power of 2, 2..64).
REQ-004 SHALL have parameter LINES, default 16, meaning lines (power of 2, 2..256), direct-mapped.
REQ-005 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-high reset.
REQ-006 SHALL have ports: dcache_addr in ADDRBITS, byte address; dcache_in in DATABITS, write data; dcache_rdreq in 1; dcache_wrreq in 1; dcache_wordlen in 2, 0=byte 1=half 2/3=word.
REQ-007 SHALL have ports: dcache_out out DATABITS, read data; dcache_out_valid out 1, read-data strobe; dcache_ready out 1, request may be accepted.
REQ-008 SHALL have port dcache_flush in 1, requesting write-back of all dirty lines.
REQ-009 SHALL have ports: mem_addr out ADDRBITS; mem_in out DATABITS, write data to memory; mem_out in DATABITS; mem_out_valid in 1; mem_rdreq out 1; mem_wrreq out 1; mem_burstlen out 16, constant LINEWORDS.

Function
REQ-010 SHALL accept a request in cycles where dcache_ready=1; when rdreq and wrreq are both high, SHALL perform the write and ignore the read.
REQ-011 SHALL derive offset/index/tag from dcache_addr; sub-word accesses use addr[1:0] for lane (half uses addr[1]); misaligned low bits SHALL be ignored.
REQ-012 SHALL, on read hit, assert dcache_out_valid exactly one cycle after acceptance, data zero-extended from selected lane; ready stays 1.
REQ-013 SHALL, on write hit, merge only selected bytes, set line dirty; ready stays 1; no out_valid.
REQ-014 SHALL, on miss, drop ready the next cycle and run states IDLE -> (WB if victim valid+dirty) -> FILL -> DONE -> IDLE.
REQ-015 SHALL in WB drive mem_wrreq=1 for LINEWORDS consecutive cycles, mem_addr = victim line base + 4*beat, mem_in = that word.
REQ-016 SHALL in FILL drive mem_rdreq=1 for LINEWORDS consecutive cycles with incrementing addresses, and store mem_out at each mem_out_valid beat in order; leave FILL after the LINEWORDS-th valid beat.
REQ-017 SHALL in DONE perform the pending access on the filled line (read: out_valid that cycle), mark line valid (dirty if write), return to IDLE with ready=1 next cycle.
REQ-018 SHALL, when dcache_flush is high in IDLE (priority over requests), enter FLUSH: scan index 0..LINES-1, write back each valid dirty line as in REQ-015, clear dirty; ready=0 throughout; return to IDLE after last index.
REQ-019 SHALL ignore dcache_flush outside IDLE; SHALL never assert mem_rdreq and mem_wrreq together.
REQ-020 SHALL hold mem_rdreq, mem_wrreq low in IDLE and DONE.

Reset
REQ-021 SHALL on reset clear all valid and dirty bits in one cycle, state=IDLE, dcache_ready=1, dcache_out_valid=0, mem_rdreq=0, mem_wrreq=0, mem_addr=0, dcache_out=0.
REQ-022 SHALL on reset mid-WB/FILL/FLUSH abort immediately; unwritten dirty data lost; memory strobes low next cycle.

Configuration
REQ-023 SHALL, with DCACHE_WB_STATS_EN defined, add outputs stat_hits out 32 and stat_misses out 32, saturating counters of accepted accesses, cleared by reset.
REQ-024 SHALL, without DCACHE_WB_STATS_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-025 SHALL place state encoding, wordlen constants and offset/index/tag width functions in package dcache_wb_pkg.
REQ-026 SHALL implement line data storage in sub-module dcache_wb_dataram (single-port, byte-enable write, combinational read); tags/valid/dirty in registers.

Verification
REQ-027 Write 0fff0001 word to 00000080 after reset -> miss, 8 mem_rdreq beats from 00000080, then ready=1; read 00000080 -> 0fff0001 one cycle later, no memory traffic.
REQ-028 Byte writes aa to 00000101, bb to 00000103, read word 00000100 -> bb00aa00 (memory initially zero).
REQ-029 Write 11111111 to 00000000, then read 00000200 (LINES=16, LINEWORDS=8, same index) -> 8 mem_wrreq beats 00000000..0000001c first, then 8-beat fill of 00000200.
REQ-030 Dirty lines at indices 0 and 4, assert dcache_flush -> exactly 16 write beats, index 0 first; then a read of either line hits without memory traffic.
REQ-031 Simultaneous rdreq+wrreq 0000aa55 to 00000080 -> no out_valid, subsequent read returns 0000aa55.
REQ-032 Reset asserted at 3rd FILL beat -> strobes low next cycle, ready=1, re-read of same address misses.
